// File: rtl/imm_encoder.sv
// Packs a 64-bit immediate and register fields into an RV64 instruction word; LI expands to LUI+ADDIW.
// Define IMM_ENCODER_LI_COMPRESS_EN to emit LI as a single ADDI or LUI when one half is zero.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_imm_type,
  input  logic [63:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  state_t      state;
  logic [31:0] beat2;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        err;
  logic        last1;
  logic [31:0] li_sum;
  logic [19:0] hi;
  logic [11:0] lo;
  logic        unused;

  // Every immediate type overwrites all funct7 bit positions.
  assign unused   = &{1'b0, in_funct7, li_sum[11:0]};
  assign in_ready = !out_valid || (out_ready && out_last);

  always_comb begin
    li_sum = in_imm[31:0] + 32'h800;
    hi     = li_sum[31:12];
    lo     = in_imm[11:0];
    word1  = '0;
    word2  = '0;
    err    = 1'b0;
    last1  = 1'b1;
    case (in_imm_type)
      3'b000: begin
        err   = in_imm != {{52{in_imm[11]}}, in_imm[11:0]};
        word1 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      3'b001: begin
        err   = in_imm != {{52{in_imm[11]}}, in_imm[11:0]};
        word1 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      3'b010: begin
        err   = (in_imm != {{51{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
        word1 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], in_opcode};
      end
      3'b011: begin
        err   = (in_imm[63:32] != 32'h0) || (in_imm[11:0] != 12'h0);
        word1 = {in_imm[31:12], in_rd, in_opcode};
      end
      3'b100: begin
        err   = (in_imm != {{43{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
        word1 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      3'b101: begin
        err   = in_imm != {{32{in_imm[31]}}, in_imm[31:0]};
        word1 = {hi, in_rd, 7'b0110111};
        word2 = {lo, in_rd, 3'b000, in_rd, 7'b0011011};
        last1 = 1'b0;
`ifdef IMM_ENCODER_LI_COMPRESS_EN
        if (hi == 20'h0) begin
          word1 = {lo, 5'd0, 3'b000, in_rd, 7'b0010011};
          last1 = 1'b1;
        end else if (lo == 12'h0) begin
          last1 = 1'b1;
        end
`endif
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      word1 = '0;
      last1 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
      beat2     <= '0;
    end else if (in_valid && in_ready) begin
      state     <= EMIT;
      out_valid <= 1'b1;
      out_instr <= word1;
      out_err   <= err;
      out_last  <= last1;
      beat2     <= word2;
    end else if (out_valid && out_ready) begin
      // in_ready is low on LI beat 1, so a handshake here always advances to beat 2.
      if (state == EMIT && !out_last) begin
        state     <= EMIT2;
        out_instr <= beat2;
        out_last  <= 1'b1;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
